// File: rtl/prog_mem_mp.sv
// Dual-read (fetch A / load B), single-write program memory with a zero-fill INIT sequencer.
// Optional write-to-read bypass is compiled in with `define PROG_MEM_BYPASS_EN.
module prog_mem_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req_i,
    input  logic [ADDR_W-1:0]     a_addr_i,
    output logic                  a_ready_o,
    output logic                  a_valid_o,
    output logic [DATA_W-1:0]     a_data_o,
    output logic                  a_err_o,
    input  logic                  b_req_i,
    input  logic [ADDR_W-1:0]     b_addr_i,
    output logic                  b_ready_o,
    output logic                  b_valid_o,
    output logic [DATA_W-1:0]     b_data_o,
    output logic                  b_err_o,
    input  logic                  w_req_i,
    input  logic [ADDR_W-1:0]     w_addr_i,
    input  logic [DATA_W-1:0]     w_data_i,
    input  logic [DATA_W/8-1:0]   w_be_i,
    output logic                  w_ack_o,
    output logic                  w_err_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_fill;
    logic                r_ready;
    logic                r_a_valid, r_b_valid, r_a_err, r_b_err;
    logic [DATA_W-1:0]   r_a_data, r_b_data;
    logic                r_w_ack, r_w_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_a_word, w_b_word, w_w_word;
    logic                w_a_oor, w_b_oor, w_w_oor;
    logic [IDX_W-1:0]    w_a_idx, w_b_idx, w_w_idx;
    logic                w_run, w_a_acc, w_b_acc, w_w_acc, w_w_hit;
    logic [DATA_W-1:0]   w_a_rdata, w_b_rdata;
    logic                w_mem_we;
    logic [IDX_W-1:0]    w_mem_idx;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [BYTES-1:0]    w_mem_be;

    // Word index drops the byte offset; anything at or beyond DEPTH is out of range.
    assign w_a_word = a_addr_i >> OFF_W;
    assign w_b_word = b_addr_i >> OFF_W;
    assign w_w_word = w_addr_i >> OFF_W;
    assign w_a_oor  = (w_a_word >= DEPTH_A);
    assign w_b_oor  = (w_b_word >= DEPTH_A);
    assign w_w_oor  = (w_w_word >= DEPTH_A);
    assign w_a_idx  = w_a_word[IDX_W-1:0];
    assign w_b_idx  = w_b_word[IDX_W-1:0];
    assign w_w_idx  = w_w_word[IDX_W-1:0];

    assign w_run   = (r_state == ST_RUN);
    assign w_a_acc = w_run & a_req_i;
    assign w_b_acc = w_run & b_req_i;
    assign w_w_acc = w_run & w_req_i;
    assign w_w_hit = w_w_acc & ~w_w_oor;

`ifdef PROG_MEM_BYPASS_EN
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BYTES-1:0]  be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < BYTES; b++)
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        return res;
    endfunction

    assign w_a_rdata = (w_w_hit && (w_w_idx == w_a_idx)) ? merge(r_mem[w_a_idx], w_data_i, w_be_i)
                                                          : r_mem[w_a_idx];
    assign w_b_rdata = (w_w_hit && (w_w_idx == w_b_idx)) ? merge(r_mem[w_b_idx], w_data_i, w_be_i)
                                                          : r_mem[w_b_idx];
`else
    assign w_a_rdata = r_mem[w_a_idx];
    assign w_b_rdata = r_mem[w_b_idx];
`endif

    // Single write port shared by the INIT zero-fill and RUN-time byte writes.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = r_fill;
        w_mem_wdata = '0;
        w_mem_be    = '1;
        if (rst) begin
            if (r_state == ST_INIT) begin
                w_mem_we = 1'b1;
            end else if (w_w_hit) begin
                w_mem_we    = 1'b1;
                w_mem_idx   = w_w_idx;
                w_mem_wdata = w_data_i;
                w_mem_be    = w_be_i;
            end
        end
    end

    // NOTE: the array has no reset branch so it maps onto RAM; INIT clears it instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < BYTES; b++)
                if (w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
        end
    end

    // NOTE: all state updates are non-blocking so reads in this block see the pre-edge memory.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_INIT;
            r_fill    <= '0;
            r_ready   <= 1'b0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_a_err   <= 1'b0;
            r_b_err   <= 1'b0;
            r_a_data  <= '0;
            r_b_data  <= '0;
            r_w_ack   <= 1'b0;
            r_w_err   <= 1'b0;
        end else begin
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_a_err   <= 1'b0;
            r_b_err   <= 1'b0;
            r_w_ack   <= 1'b0;
            r_w_err   <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_fill <= r_fill + 1'b1;
                    if (r_fill == LAST_IDX) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_a_acc) begin
                        r_a_valid <= 1'b1;
                        r_a_err   <= w_a_oor;
                        r_a_data  <= w_a_oor ? '0 : w_a_rdata;
                    end
                    if (w_b_acc) begin
                        r_b_valid <= 1'b1;
                        r_b_err   <= w_b_oor;
                        r_b_data  <= w_b_oor ? '0 : w_b_rdata;
                    end
                    if (w_w_acc) begin
                        r_w_ack <= 1'b1;
                        r_w_err <= w_w_oor;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign a_ready_o = r_ready;
    assign b_ready_o = r_ready;
    assign a_valid_o = r_a_valid;
    assign b_valid_o = r_b_valid;
    assign a_err_o   = r_a_err;
    assign b_err_o   = r_b_err;
    assign a_data_o  = r_a_data;
    assign b_data_o  = r_b_data;
    assign w_ack_o   = r_w_ack;
    assign w_err_o   = r_w_err;

endmodule

// File: doc/prog_mem_mp.md
PROG_MEM_MP -- requirements
Module: prog_mem_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 4096: number of words; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have ports a_req_i, input, 1 and b_req_i, input, 1: read requests on fetch port A and load port B.
REQ-007 SHALL have ports a_addr_i, input, ADDR_W and b_addr_i, input, ADDR_W: read byte addresses.
REQ-008 SHALL have ports a_ready_o, output, 1 and b_ready_o, output, 1: port accepts a request this cycle.
REQ-009 SHALL have ports a_valid_o, output, 1 and b_valid_o, output, 1: one-cycle pulse, read data present.
REQ-010 SHALL have ports a_data_o, output, DATA_W and b_data_o, output, DATA_W: read data.
REQ-011 SHALL have ports a_err_o, output, 1 and b_err_o, output, 1: out-of-range read, qualified by valid.
REQ-012 SHALL have port w_req_i, input, 1: write request.
REQ-013 SHALL have port w_addr_i, input, ADDR_W: write byte address.
REQ-014 SHALL have port w_data_i, input, DATA_W: write data.
REQ-015 SHALL have port w_be_i, input, DATA_W/8: byte enables; bit n covers bits 8n+7:8n.
REQ-016 SHALL have port w_ack_o, output, 1: one-cycle pulse, write completed.
REQ-017 SHALL have port w_err_o, output, 1: out-of-range write, qualified by w_ack_o.

Function
REQ-018 SHALL form the word index from addr bits above log2(DATA_W/8); the low offset bits SHALL be ignored.
REQ-019 SHALL treat a word index of DEPTH or more as out of range.
REQ-020 SHALL implement a two-state sequencer: INIT and RUN.
REQ-021 In INIT, SHALL zero-fill one word per cycle from index 0 to DEPTH-1, then enter RUN; INIT lasts DEPTH cycles.
REQ-022 In INIT, SHALL hold a_ready_o, b_ready_o and w_ack_o at 0 and ignore all requests.
REQ-023 In RUN, a_ready_o and b_ready_o SHALL be 1 every cycle; a read is accepted when req_i=1 and ready_o=1.
REQ-024 An accepted read SHALL produce valid_o=1 exactly one cycle later, carrying the registered word.
REQ-025 Ports A and B SHALL be fully independent; both may read any addresses, including the same one, in the same cycle.
REQ-026 data_o SHALL hold its last value until the next accepted read on that port.
REQ-027 An out-of-range read SHALL return data_o=0 with err_o=1 alongside valid_o.
REQ-028 In RUN, a write with w_req_i=1 SHALL update only the bytes enabled in w_be_i, accepting one write per cycle.
REQ-029 A write SHALL pulse w_ack_o one cycle after acceptance.
REQ-030 A write with w_be_i=0 SHALL leave memory unchanged and still pulse w_ack_o.
REQ-031 An out-of-range write SHALL leave memory unchanged and pulse w_ack_o together with w_err_o=1.
REQ-032 A read and a write to the same word in the same cycle: the result SHALL follow REQ-039.

Reset
REQ-033 When rst=0 at a clock edge, the block SHALL enter INIT with the fill counter at 0.
REQ-034 On reset, all valid_o, err_o, w_ack_o, w_err_o and ready_o SHALL be 0 and data_o SHALL be 0.
REQ-035 Reset mid-operation SHALL drop in-flight reads and writes without a valid_o or ack pulse, then re-run the full zero-fill.
REQ-036 While rst=0, outputs SHALL stay at their reset values.

Configuration
REQ-037 SHALL compile write-to-read bypass in only when PROG_MEM_BYPASS_EN is defined.
REQ-038 Without PROG_MEM_BYPASS_EN, a same-cycle read and write to one word SHALL return the pre-write word.
REQ-039 With PROG_MEM_BYPASS_EN, that read SHALL return the merged result: enabled bytes from w_data_i, other bytes from the old word; applies per port.

Verification
REQ-040 Reset then INIT: hold rst=0 for 2 cycles, release -> ready_o=0 for DEPTH cycles then 1; a read of index 5 -> data 0, err 0.
REQ-041 Byte-enable write: write 0xAABBCCDD at 0x10 with be=0xF, then write 0x11223344 with be=0x5 -> reading 0x10 returns 0xAA22CC44, valid one cycle after request.
REQ-042 Dual port: preload 0x100=0x1, 0x104=0x2 -> same-cycle reads A=0x100, B=0x104 return 0x1 and 0x2; both ports reading 0x104 both return 0x2.
REQ-043 Out of range (DEPTH=4096): read 0x4000 -> data 0, err 1; write 0x4000 -> ack 1, err 1, memory unchanged.
REQ-044 Collision: word 0x20=0x0, same-cycle write 0xFFFFFFFF be=0x3 and read 0x20 -> 0x00000000 without bypass, 0x0000FFFF with PROG_MEM_BYPASS_EN.
REQ-045 Reset mid-run: after writing 0x20=0x5, assert rst=0 in the cycle a read is accepted -> no valid pulse; after re-init, read 0x20 returns 0.
